tlb_op_ctrl: RTL

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

---
 rtl/tlb_op_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB instruction controller: accepts one TLB op at a time, latches its
// CSR snapshot, handshakes with the TLB (req/ack) and returns the
// search/read results as CSR write-back values with single-cycle pulses.
module tlb_op_ctrl (
    input  logic        clk,
    input  logic        rst,
    // instruction side
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_type,
    input  logic [4:0]  inv_op,
    input  logic [9:0]  inv_asid,
    input  logic [18:0] inv_va,
    input  logic        flush,
    // CSR snapshot
    input  logic [31:0] csr_tlbidx,
    input  logic [31:0] csr_tlbehi,
    input  logic [31:0] csr_tlbelo0,
    input  logic [31:0] csr_tlbelo1,
    input  logic [9:0]  csr_asid,
    input  logic [5:0]  csr_ecode,
    // TLB side
    output logic        tlb_req,
    output logic [2:0]  tlb_cmd,
    output logic [4:0]  tlb_index,
    output logic        tlb_w_e,
    output logic [31:0] tlb_w_idx,
    output logic [31:0] tlb_w_ehi,
    output logic [31:0] tlb_w_elo0,
    output logic [31:0] tlb_w_elo1,
    output logic [9:0]  tlb_asid,
    output logic [4:0]  tlb_inv_op,
    output logic [9:0]  tlb_inv_asid,
    output logic [18:0] tlb_inv_va,
    input  logic        tlb_ack,
    input  logic        tlb_found,
    input  logic [4:0]  tlb_found_index,
    input  logic        tlb_rd_e,
    input  logic [31:0] tlb_rd_idx,
    input  logic [31:0] tlb_rd_ehi,
    input  logic [31:0] tlb_rd_elo0,
    input  logic [31:0] tlb_rd_elo1,
    input  logic [9:0]  tlb_rd_asid,
    // CSR write-back
    output logic        tlbsrch_ret,
    output logic        search_tlb_found,
    output logic [4:0]  search_tlb_index,
    output logic        tlbrd_ret,
    output logic        tlbrd_valid,
    output logic [31:0] tlbidx_out,
    output logic [31:0] tlbehi_out,
    output logic [31:0] tlbelo0_out,
    output logic [31:0] tlbelo1_out,
    output logic [9:0]  asid_out,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t      r_state, w_next;
    logic        w_accept, w_ack, w_ret_ok;
    logic [4:0]  r_fill_cnt, r_fill_idx;
    logic        r_flushed;
    logic [2:0]  r_op;
    logic [4:0]  r_inv_op;
    logic [9:0]  r_inv_asid;
    logic [18:0] r_inv_va;
    logic [31:0] r_tlbidx, r_tlbehi, r_tlbelo0, r_tlbelo1;
    logic [9:0]  r_asid;
    logic [5:0]  r_ecode;
    logic        r_s_found;
    logic [4:0]  r_s_index;
    logic        r_rd_valid;
    logic [31:0] r_rd_idx, r_rd_ehi, r_rd_elo0, r_rd_elo1;
    logic [9:0]  r_rd_asid;

    assign w_accept = op_valid & op_ready;
    // ack only counts while a request is outstanding
    assign w_ack    = (r_state == S_REQ) & tlb_ack;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // next-state logic; reserved op codes skip the TLB and go straight to RESP
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (op_type > OP_INV) ? S_RESP : S_REQ;
            S_REQ:   if (tlb_ack) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs; a flush in REQ or in RESP itself kills the ret pulses
    always_comb begin
        op_ready    = (r_state == S_IDLE) & ~flush;
        busy        = (r_state == S_REQ) | (r_state == S_RESP);
        tlb_req     = (r_state == S_REQ);
        done        = (r_state == S_RESP);
        w_ret_ok    = (r_state == S_RESP) & ~r_flushed & ~flush;
        tlbsrch_ret = w_ret_ok & (r_op == OP_SRCH);
        tlbrd_ret   = w_ret_ok & (r_op == OP_RD);
    end

    // free-running fill slot counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fill_cnt <= '0;
        else      r_fill_cnt <= r_fill_cnt + 5'd1;
    end

    // request / CSR snapshot taken on acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= '0;
            r_inv_op   <= '0;
            r_inv_asid <= '0;
            r_inv_va   <= '0;
            r_tlbidx   <= '0;
            r_tlbehi   <= '0;
            r_tlbelo0  <= '0;
            r_tlbelo1  <= '0;
            r_asid     <= '0;
            r_ecode    <= '0;
            r_fill_idx <= '0;
        end else if (w_accept) begin
            r_op       <= op_type;
            r_inv_op   <= inv_op;
            r_inv_asid <= inv_asid;
            r_inv_va   <= inv_va;
            r_tlbidx   <= csr_tlbidx;
            r_tlbehi   <= csr_tlbehi;
            r_tlbelo0  <= csr_tlbelo0;
            r_tlbelo1  <= csr_tlbelo1;
            r_asid     <= csr_asid;
            r_ecode    <= csr_ecode;
            r_fill_idx <= r_fill_cnt;
        end
    end

    // remember a flush seen while the TLB op was in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_flushed <= 1'b0;
        else if (w_accept)                 r_flushed <= 1'b0;
        else if (r_state == S_REQ && flush) r_flushed <= 1'b1;
    end

    // capture TLB results on the ack cycle; an invalid read returns NE=1, rest 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_found  <= 1'b0;
            r_s_index  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_ehi   <= '0;
            r_rd_elo0  <= '0;
            r_rd_elo1  <= '0;
            r_rd_asid  <= '0;
        end else if (w_ack) begin
            if (r_op == OP_SRCH) begin
                r_s_found <= tlb_found;
                r_s_index <= tlb_found_index;
            end
            if (r_op == OP_RD) begin
                r_rd_valid <= tlb_rd_e;
                r_rd_idx   <= tlb_rd_e ? tlb_rd_idx  : 32'h8000_0000;
                r_rd_ehi   <= tlb_rd_e ? tlb_rd_ehi  : 32'h0;
                r_rd_elo0  <= tlb_rd_e ? tlb_rd_elo0 : 32'h0;
                r_rd_elo1  <= tlb_rd_e ? tlb_rd_elo1 : 32'h0;
                r_rd_asid  <= tlb_rd_e ? tlb_rd_asid : 10'h0;
            end
        end
    end

    // TLB command fields come from the snapshot so they stay stable through REQ;
    // a forced write (ecode 3F) always marks the entry present
    always_comb begin
        tlb_cmd      = r_op;
        tlb_index    = (r_op == OP_FILL) ? r_fill_idx : r_tlbidx[4:0];
        tlb_w_e      = ((r_op == OP_WR) || (r_op == OP_FILL)) ?
                       ((r_ecode == 6'h3F) ? 1'b1 : ~r_tlbidx[31]) : 1'b0;
        tlb_w_idx    = r_tlbidx;
        tlb_w_ehi    = r_tlbehi;
        tlb_w_elo0   = r_tlbelo0;
        tlb_w_elo1   = r_tlbelo1;
        tlb_asid     = r_asid;
        tlb_inv_op   = r_inv_op;
        tlb_inv_asid = r_inv_asid;
        tlb_inv_va   = r_inv_va;
    end

    // write-back data holds until the next search/read completes
    always_comb begin
        search_tlb_found = r_s_found;
        search_tlb_index = r_s_index;
        tlbrd_valid      = r_rd_valid;
        tlbidx_out       = r_rd_idx;
        tlbehi_out       = r_rd_ehi;
        tlbelo0_out      = r_rd_elo0;
        tlbelo1_out      = r_rd_elo1;
        asid_out         = r_rd_asid;
    end

endmodule
